p18240_datapath: RTL and testbench
==================================

# p18240_datapath

Register-transfer datapath for the p18240 16-bit CPU. Holds the windowed register file, PC, SP, IR, MAR, MDR, ALU and ZCNV condition codes. Executes one register transfer per clock under flattened control points from the controlpath FSM. Drives the memory address/data bus and exposes all state for the seven-segment display and simulation trace.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- alu_op  in  4  0 ADD, 1 SUB(A−B), 2 INC(A+1), 3 DEC(A−1), 4 AND, 5 OR, 6 XOR, 7 NOT(~A), 8 SHL, 9 SHR logical, 10 ASHR, 11 PASSA, 12 PASSB; 13–15 behave as PASSA
- srcA  in  2  0 reg[regSelA], 1 PC, 2 MDR, 3 SP
- srcB  in  2  0 reg[regSelB], 1 MDR, 2 PC, 3 SP
- dest  in  3  0 none, 1 reg[regSelA], 2 PC, 3 IR, 4 MAR, 5 MDR, 6 SP, 7 none
- lcc_L  in  1  low: load ZCNV from ALU
- re_L  in  1  low: MDR captures dataBus
- we_L  in  1  low: datapath drives MDR onto dataBus
- winAddSub  in  2  01 window+1, 10 window−1, 00/11 hold
- dataBus  inout  16  memory data bus
- ir, pc, sp  out  16  architectural registers
- memAddr  out  16  = MAR
- MDRout  out  16  = MDR
- aluSrcA, aluSrcB, aluResult  out  16  ALU inputs/output
- condCodes  out  4  {Z,C,N,V}
- regSelA, regSelB  out  3  ir[5:3], ir[2:0]
- viewReg  out  128  {R7..R0} of current window
- w  out  1  window fault flag

## Operation
- Register file: R0–R3 global; R4–R7 banked, 4 windows (20 physical regs). 2-bit window pointer selects the bank for reads, writes, viewReg.
- ALU combinational from muxed sources; 16-bit wrap-around arithmetic.
- Flags: Z = result==0; N = result[15]. ADD/INC: C = carry out, V = signed overflow. SUB/DEC: computed as A+~B+1 (DEC: B=1); C = carry out (1 = no borrow), V = signed overflow. SHL: C = A[15]; SHR/ASHR: C = A[0]; V=0. Logic/pass: C=V=0.
- dest writes aluResult into the selected register at the clock edge; dest 0/7 writes nothing.
- MDR: re_L=0 loads dataBus, overriding dest=MDR in the same cycle.
- dataBus driven with MDR only when we_L=0 and re_L=1; else high-Z.
- Window: 01 at window 3 or 10 at window 0 leaves the pointer unchanged and sets w=1. Any legal change clears w. Hold keeps w.

## Timing
- All state updates on posedge clock; reset asynchronous. Reset values: all registers, window pointer, ZCNV, w = 0. Outputs therefore read 0 during and after reset.
- Write to reg[regSelA] is visible on viewReg and aluSrcA the cycle after the edge. No bypass.
- dest=IR changes regSelA/B after the edge.
- Window change takes effect at the edge. A register write in the same cycle uses the old window.
- Read/write latency 1 cycle: MAR loaded at edge N; memory read with re_L low in cycle N+1; MDR valid after edge N+2.
- lcc_L high keeps ZCNV.

## Test plan
- Reset mid-operation with R1=0x1234, PC=5 → every output 0, dataBus Z, w=0.
- R1=0x7FFF, R2=0x0001 (IR=0x000A), ADD, dest=reg, lcc_L=0 → R1=0x8000, ZCNV=0011.
- SUB of 0x0005−0x0005 → result 0, ZCNV=1100. SHR of 0x0001 → 0, C=1.
- MAR=0x0010; re_L=0 with dataBus=0xBEEF and dest=MDR → MDRout=0xBEEF. we_L=0 → dataBus=0xBEEF.
- Write R5=0xAAAA in window 0, winAddSub=01, write R5=0x5555 → viewReg R5=0x5555; winAddSub=10 → R5=0xAAAA; R0 shared across windows.
- winAddSub=10 at window 0 → w=1, window stays 0. Then 01 → w=0, window 1.

Source files
------------

// File: rtl/p18240_datapath_if.sv
// Control-point and observation bundle for the p18240 datapath.
// master: controlpath / bench side, drives the control points and reads the state.
// slave : datapath side, takes the control points and presents its state.
// Control points: alu_op, srcA, srcB, dest, lcc_L, re_L, we_L, winAddSub.
// Observations  : ir, pc, sp, memAddr, MDRout, aluSrcA/B, aluResult,
//                 condCodes {Z,C,N,V}, regSelA/B, viewReg {R7..R0}, w.
interface p18240_datapath_if;
  logic [3:0]   alu_op;
  logic [1:0]   srcA, srcB;
  logic [2:0]   dest;
  logic         lcc_L, re_L, we_L;
  logic [1:0]   winAddSub;
  logic [15:0]  ir, pc, sp, memAddr, MDRout;
  logic [15:0]  aluSrcA, aluSrcB, aluResult;
  logic [3:0]   condCodes;
  logic [2:0]   regSelA, regSelB;
  logic [127:0] viewReg;
  logic         w;

  modport master (
    output alu_op, srcA, srcB, dest, lcc_L, re_L, we_L, winAddSub,
    input  ir, pc, sp, memAddr, MDRout, aluSrcA, aluSrcB, aluResult,
           condCodes, regSelA, regSelB, viewReg, w
  );

  modport slave (
    input  alu_op, srcA, srcB, dest, lcc_L, re_L, we_L, winAddSub,
    output ir, pc, sp, memAddr, MDRout, aluSrcA, aluSrcB, aluResult,
           condCodes, regSelA, regSelB, viewReg, w
  );
endinterface

// File: rtl/p18240_datapath.sv
// p18240 16-bit CPU datapath: windowed register file (R0-R3 global, R4-R7
// banked over 4 windows), PC, SP, IR, MAR, MDR, ALU and ZCNV flags. One
// register transfer per clock under the control points carried by dp.
// Ports: clock, reset (async, active high), dp (control/observation bundle,
// slave side), dataBus (bidirectional memory data bus, driven with MDR only
// while we_L=0 and re_L=1).
module p18240_datapath (
  input  logic                 clock,
  input  logic                 reset,
  p18240_datapath_if.slave     dp,
  inout  wire  [15:0]          dataBus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2,
    OP_DEC = 4'd3, OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
    OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ASHR = 4'd10, OP_PASSB = 4'd12;

  logic [15:0]      gregs [4];
  logic [15:0]      bregs [4][4];   // [window][R4..R7]
  logic [15:0]      pc, sp, ir, mar, mdr;
  logic [3:0]       zcnv;
  logic [1:0]       win;
  logic             wflag;

  logic [7:0][15:0] view;
  logic [15:0]      a, b, res;
  logic [16:0]      sum;
  logic             c, v;

  // Architectural view of the current window; both ALU read ports come from it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      view[i]   = gregs[i];
      view[i+4] = bregs[win][i];
    end
  end

  always_comb begin
    case (dp.srcA)
      2'd0:    a = view[ir[5:3]];
      2'd1:    a = pc;
      2'd2:    a = mdr;
      default: a = sp;
    endcase
    case (dp.srcB)
      2'd0:    b = view[ir[2:0]];
      2'd1:    b = mdr;
      2'd2:    b = pc;
      default: b = sp;
    endcase
  end

  // Subtractions run as A + ~B + 1 so C is the carry out (1 = no borrow).
  always_comb begin
    sum = '0;
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    case (dp.alu_op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[15:0]; c = sum[16];
        v   = (a[15] == b[15]) && (res[15] != a[15]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
        res = sum[15:0]; c = sum[16];
        v   = (a[15] != b[15]) && (res[15] != a[15]);
      end
      OP_INC: begin
        sum = {1'b0, a} + 17'd1;
        res = sum[15:0]; c = sum[16];
        v   = !a[15] && res[15];
      end
      OP_DEC: begin
        sum = {1'b0, a} + 17'h0FFFF;   // A + ~1 + 1
        res = sum[15:0]; c = sum[16];
        v   = a[15] && !res[15];
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT:   res = ~a;
      OP_SHL:  begin res = {a[14:0], 1'b0};    c = a[15]; end
      OP_SHR:  begin res = {1'b0, a[15:1]};    c = a[0];  end
      OP_ASHR: begin res = {a[15], a[15:1]};   c = a[0];  end
      OP_PASSB: res = b;
      default:  res = a;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        gregs[i] <= '0;
        for (int j = 0; j < 4; j++) bregs[i][j] <= '0;
      end
      pc <= '0; sp <= '0; ir <= '0; mar <= '0; mdr <= '0;
      zcnv <= '0; win <= '0; wflag <= 1'b0;
    end else begin
      // Register write uses the window and IR from before this edge.
      case (dp.dest)
        3'd1: begin
          if (ir[5]) bregs[win][ir[4:3]] <= res;
          else       gregs[ir[4:3]]      <= res;
        end
        3'd2:    pc  <= res;
        3'd3:    ir  <= res;
        3'd4:    mar <= res;
        3'd6:    sp  <= res;
        default: ;
      endcase
      if (!dp.re_L)            mdr <= dataBus;
      else if (dp.dest == 3'd5) mdr <= res;
      if (!dp.lcc_L) zcnv <= {res == 16'd0, c, res[15], v};
      case (dp.winAddSub)
        2'b01: begin
          if (win == 2'd3) wflag <= 1'b1;
          else begin win <= win + 2'd1; wflag <= 1'b0; end
        end
        2'b10: begin
          if (win == 2'd0) wflag <= 1'b1;
          else begin win <= win - 2'd1; wflag <= 1'b0; end
        end
        default: ;
      endcase
    end
  end

  assign dataBus      = (!dp.we_L && dp.re_L) ? mdr : 16'bz;
  assign dp.ir        = ir;
  assign dp.pc        = pc;
  assign dp.sp        = sp;
  assign dp.memAddr   = mar;
  assign dp.MDRout    = mdr;
  assign dp.aluSrcA   = a;
  assign dp.aluSrcB   = b;
  assign dp.aluResult = res;
  assign dp.condCodes = zcnv;
  assign dp.regSelA   = ir[5:3];
  assign dp.regSelB   = ir[2:0];
  assign dp.viewReg   = view;
  assign dp.w         = wflag;
endmodule

// File: tb/tb_p18240_datapath.sv
// Self-checking bench for p18240_datapath: directed steps followed by random
// transfers, all compared against a behavioural model of the architecture
// (flat physical register array, integer arithmetic for the ALU and flags).
module tb_p18240_datapath;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tb_en = 1'b1;
  logic [15:0] tb_val = '0;
  wire  [15:0] dataBus;
  int          tests = 0;
  int          fails = 0;

  p18240_datapath_if bif ();
  p18240_datapath dut (.clock(clock), .reset(reset), .dp(bif), .dataBus(dataBus));

  assign dataBus = tb_en ? tb_val : 16'bz;
  always #5 clock = ~clock;

  // Model state.
  logic [15:0] m_reg [20];
  logic [15:0] m_pc, m_sp, m_ir, m_mar, m_mdr;
  logic [3:0]  m_cc;
  logic [1:0]  m_win;
  logic        m_w;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pidx(input logic [2:0] s, input logic [1:0] wn);
    return (s < 3'd4) ? int'(s) : 4 + 4 * int'(wn) + int'(s) - 4;
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] s);
    return m_reg[pidx(s, m_win)];
  endfunction

  function automatic logic [19:0] m_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, sr;
    logic [15:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = a; c = 1'b0; v = 1'b0; sr = 0;
    case (op)
      4'd0: begin r = 16'(ua + ub); c = (ua + ub) > 65535; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      4'd1: begin r = 16'(ua - ub); c = ua >= ub; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      4'd2: begin r = 16'(ua + 1); c = ua == 65535; v = sa == 32767; end
      4'd3: begin r = 16'(ua - 1); c = ua >= 1; v = sa == -32768; end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      4'd8: begin r = 16'(ua * 2); c = ua >= 32768; end
      4'd9: begin r = 16'(ua / 2); c = (ua % 2) == 1; end
      4'd10: begin r = 16'(sa >>> 1); c = (ua % 2) == 1; end
      4'd12: r = b;
      default: r = a;
    endcase
    return {r == 16'd0, c, r[15], v, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 20; i++) m_reg[i] = '0;
    m_pc = '0; m_sp = '0; m_ir = '0; m_mar = '0; m_mdr = '0;
    m_cc = '0; m_win = '0; m_w = 1'b0;
  endtask

  task automatic check_state();
    logic [127:0] vv;
    for (int i = 0; i < 8; i++) vv[16*i +: 16] = m_rd(3'(i));
    chk("pc", bif.pc, m_pc);
    chk("sp", bif.sp, m_sp);
    chk("ir", bif.ir, m_ir);
    chk("memAddr", bif.memAddr, m_mar);
    chk("MDRout", bif.MDRout, m_mdr);
    chk("condCodes", bif.condCodes, m_cc);
    chk("w", bif.w, m_w);
    chk("regSelA", bif.regSelA, m_ir[5:3]);
    chk("regSelB", bif.regSelB, m_ir[2:0]);
    chk("viewReg", bif.viewReg, vv);
  endtask

  // One transfer: called just after a falling edge, returns after the next one.
  task automatic do_op(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [2:0] dst, input logic lcc, input logic re, input logic we,
                       input logic [1:0] wa, input logic drv, input logic [15:0] bv);
    logic [15:0] a, b, res;
    logic [19:0] ar;
    bif.alu_op = op; bif.srcA = sa; bif.srcB = sb; bif.dest = dst;
    bif.lcc_L = lcc; bif.re_L = re; bif.we_L = we; bif.winAddSub = wa;
    tb_en = drv; tb_val = bv;
    #1;
    case (sa)
      2'd0: a = m_rd(m_ir[5:3]);
      2'd1: a = m_pc;
      2'd2: a = m_mdr;
      default: a = m_sp;
    endcase
    case (sb)
      2'd0: b = m_rd(m_ir[2:0]);
      2'd1: b = m_mdr;
      2'd2: b = m_pc;
      default: b = m_sp;
    endcase
    ar = m_alu(op, a, b);
    res = ar[15:0];
    chk("aluSrcA", bif.aluSrcA, a);
    chk("aluSrcB", bif.aluSrcB, b);
    chk("aluResult", bif.aluResult, res);
    chk("dataBus", dataBus, drv ? bv : m_mdr);
    // Next state, every source value taken from before the edge.
    if (dst == 3'd1) m_reg[pidx(m_ir[5:3], m_win)] = res;
    case (dst)
      3'd2: m_pc = res;
      3'd3: m_ir = res;
      3'd4: m_mar = res;
      3'd6: m_sp = res;
      default: ;
    endcase
    if (!re) m_mdr = bv;
    else if (dst == 3'd5) m_mdr = res;
    if (!lcc) m_cc = ar[19:16];
    if (wa == 2'b01) begin
      if (m_win == 2'd3) m_w = 1'b1; else begin m_win = m_win + 2'd1; m_w = 1'b0; end
    end else if (wa == 2'b10) begin
      if (m_win == 2'd0) m_w = 1'b1; else begin m_win = m_win - 2'd1; m_w = 1'b0; end
    end
    @(posedge clock); #1;
    check_state();
    @(negedge clock);
  endtask

  task automatic set_mdr(input logic [15:0] v);
    do_op(4'd11, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, v);
  endtask
  task automatic load_ir(input logic [15:0] v);
    set_mdr(v);
    do_op(4'd12, 2'd0, 2'd1, 3'd3, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
  endtask
  task automatic write_reg(input logic [15:0] v);
    set_mdr(v);
    do_op(4'd12, 2'd0, 2'd1, 3'd1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
  endtask
  task automatic win_step(input logic [1:0] wa);
    do_op(4'd11, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1, wa, 1'b1, 16'h0000);
  endtask

  initial begin
    bif.alu_op = '0; bif.srcA = '0; bif.srcB = '0; bif.dest = '0;
    bif.lcc_L = 1'b1; bif.re_L = 1'b1; bif.we_L = 1'b1; bif.winAddSub = 2'b00;
    model_reset();
    #2;
    chk("reset_pc", bif.pc, 16'h0000);
    chk("reset_view", bif.viewReg, 128'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset mid-operation.
    load_ir(16'h0008);
    write_reg(16'h1234);
    set_mdr(16'h0005);
    do_op(4'd12, 2'd0, 2'd1, 3'd2, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
    chk("pre_rst_pc", bif.pc, 16'h0005);
    tb_val = 16'h5A5A;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_state();
    chk("rst_pc", bif.pc, 16'h0000);
    chk("rst_aluResult", bif.aluResult, 16'h0000);
    chk("rst_bus_free", dataBus, 16'h5A5A);
    @(negedge clock);
    reset = 1'b0;

    // ADD overflow: 0x7FFF + 0x0001.
    load_ir(16'h0010); write_reg(16'h0001);
    load_ir(16'h000A); write_reg(16'h7FFF);
    do_op(4'd0, 2'd0, 2'd0, 3'd1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
    chk("add_r1", bif.viewReg[31:16], 16'h8000);
    chk("add_cc", bif.condCodes, 4'b0011);

    // SUB 5-5 and SHR 1.
    load_ir(16'h0010); write_reg(16'h0005);
    load_ir(16'h000A); write_reg(16'h0005);
    do_op(4'd1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
    chk("sub_cc", bif.condCodes, 4'b1100);
    write_reg(16'h0001);
    do_op(4'd9, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
    chk("shr_cc", bif.condCodes, 4'b1100);

    // Memory path: MAR load, read overriding dest=MDR, then drive.
    set_mdr(16'h0010);
    do_op(4'd12, 2'd0, 2'd1, 3'd4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 16'h0000);
    chk("mar", bif.memAddr, 16'h0010);
    do_op(4'd11, 2'd0, 2'd0, 3'd5, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'hBEEF);
    chk("mdr_read", bif.MDRout, 16'hBEEF);
    do_op(4'd11, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000);
    chk("bus_drive", dataBus, 16'hBEEF);

    // Windows: banked R5, shared R0, faults at both ends.
    reset = 1'b1; #1; model_reset(); @(negedge clock); reset = 1'b0;
    load_ir(16'h0028);
    write_reg(16'hAAAA);
    win_step(2'b01);
    write_reg(16'h5555);
    chk("win1_r5", bif.viewReg[95:80], 16'h5555);
    win_step(2'b10);
    chk("win0_r5", bif.viewReg[95:80], 16'hAAAA);
    load_ir(16'h0000);
    write_reg(16'h1111);
    win_step(2'b01);
    chk("r0_shared", bif.viewReg[15:0], 16'h1111);
    win_step(2'b10);
    win_step(2'b10);
    chk("under_w", bif.w, 1'b1);
    chk("under_r5", bif.viewReg[95:80], 16'hAAAA);
    win_step(2'b01);
    chk("recover_w", bif.w, 1'b0);
    chk("recover_r5", bif.viewReg[95:80], 16'h5555);
    win_step(2'b01); win_step(2'b01); win_step(2'b01);
    chk("over_w", bif.w, 1'b1);
    win_step(2'b00);
    chk("hold_w", bif.w, 1'b1);

    // Random transfers.
    for (int n = 0; n < 400; n++) begin
      logic re, we;
      re = 1'($urandom_range(1));
      we = 1'($urandom_range(1));
      do_op(4'($urandom_range(15)), 2'($urandom_range(3)), 2'($urandom_range(3)),
            3'($urandom_range(7)), 1'($urandom_range(1)), re, we,
            2'($urandom_range(3)), !(!we && re), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
